// File: rtl/udp_tx_sched_if.sv
// udp_tx_sched_if: producer and framer signals of the transmit scheduler
// master: scheduler side; slave: producers and framer side
// req/len0/len1: producer requests and payload lengths; tx_state: framer state code
// gnt/done/ram_sel: producer grant, completion pulse, payload RAM select
// tx_trig/tx_data_length/tx_total_length: framer trigger and length fields
// busy/err: scheduler activity and sticky watchdog error
interface udp_tx_sched_if;
  logic [1:0]  req, gnt, done;
  logic [15:0] len0, len1, tx_data_length, tx_total_length;
  logic [3:0]  tx_state;
  logic        ram_sel, tx_trig, busy, err;
  modport master(input req, len0, len1, tx_state,
                 output gnt, done, ram_sel, tx_trig, tx_data_length, tx_total_length, busy, err);
  modport slave(output req, len0, len1, tx_state,
                input gnt, done, ram_sel, tx_trig, tx_data_length, tx_total_length, busy, err);
endinterface

// File: rtl/udp_tx_sched.sv
// udp_tx_sched: round-robin transmit scheduler in front of the ipsend UDP/IP framer
// clk: clock shared with the framer; clr: asynchronous active-high reset
// bus: udp_tx_sched_if.master carrying producer handshake, framer control and status
// Optional watchdog enabled by defining UDP_TX_SCHED_WDOG_EN
module udp_tx_sched #(
  parameter int IFG_CYCLES  = 12,
  parameter int MIN_PAYLOAD = 18,
  parameter int MAX_PAYLOAD = 1472,
  parameter int WDOG_CYCLES = 4096
) (
  input logic clk,
  input logic clr,
  udp_tx_sched_if.master bus
);
  typedef enum logic [2:0] {IDLE, ARB, WAIT_START, WAIT_END, GAP} state_t;
  localparam int GW = $clog2(IFG_CYCLES + 2);
  state_t state, state_n;
  logic last, w, wd_fire;
  logic [GW-1:0] gap;
  logic [15:0] len_w, len_c;
  assign w = (bus.req == 2'b11) ? ~last : bus.req[1];
  assign len_w = w ? bus.len1 : bus.len0;
  assign len_c = (len_w < 16'(MIN_PAYLOAD)) ? 16'(MIN_PAYLOAD) :
                 (len_w > 16'(MAX_PAYLOAD)) ? 16'(MAX_PAYLOAD) : len_w;
  assign bus.tx_trig = state == WAIT_START;
  assign bus.busy = state != IDLE;
`ifdef UDP_TX_SCHED_WDOG_EN
  localparam int WW = $clog2(WDOG_CYCLES + 1);
  logic [WW-1:0] wcnt;
  logic err_q;
  // a normal state change on the same cycle takes priority over the timeout
  assign wd_fire = (wcnt == WW'(WDOG_CYCLES - 1)) &&
                   ((state == WAIT_START && bus.tx_state == '0) ||
                    (state == WAIT_END && bus.tx_state != '0));
  always_ff @(posedge clk or posedge clr)
    if (clr) begin
      wcnt  <= '0;
      err_q <= 1'b0;
    end else begin
      wcnt <= (state == WAIT_START || state == WAIT_END) ? wcnt + 1'b1 : '0;
      if (wd_fire) err_q <= 1'b1;
    end
  assign bus.err = err_q;
`else
  assign wd_fire = 1'b0;
  assign bus.err = 1'b0;
`endif
  always_ff @(posedge clk or posedge clr)
    if (clr) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:       state_n = |bus.req ? ARB : IDLE;
      ARB:        state_n = WAIT_START;
      WAIT_START: state_n = (bus.tx_state != '0) ? WAIT_END : wd_fire ? GAP : WAIT_START;
      WAIT_END:   state_n = (bus.tx_state == '0 || wd_fire) ? GAP : WAIT_END;
      GAP:        state_n = (gap == '0) ? IDLE : GAP;
      default:    state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge clr)
    if (clr) begin
      last                <= 1'b1;
      gap                 <= '0;
      bus.gnt             <= '0;
      bus.done            <= '0;
      bus.ram_sel         <= 1'b0;
      bus.tx_data_length  <= '0;
      bus.tx_total_length <= '0;
    end else begin
      bus.done <= '0;
      if (state == ARB) begin
        bus.gnt             <= w ? 2'b10 : 2'b01;
        bus.ram_sel         <= w;
        last                <= w;
        bus.tx_data_length  <= len_c + 16'd8;
        bus.tx_total_length <= len_c + 16'd28;
      end
      if (state == WAIT_END && bus.tx_state == '0) begin
        bus.done <= bus.gnt;
        bus.gnt  <= '0;
      end
      if (wd_fire) bus.gnt <= '0;
      gap <= (state != GAP && state_n == GAP) ? GW'(IFG_CYCLES) : (gap != '0) ? gap - 1'b1 : gap;
    end
endmodule

// File: tb/tb_udp_tx_sched.sv
// tb_udp_tx_sched: directed self-checking bench for udp_tx_sched with a behavioural framer
module tb_udp_tx_sched;
  logic clk = 1'b0;
  logic clr;
  int errors = 0;
  int checks = 0;
  int phase = 0;
  int fcnt = 0;
  bit frm_en = 1'b1;
  udp_tx_sched_if bus();
  udp_tx_sched dut(.clk(clk), .clr(clr), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic wait_trig(input logic v, input string tag);
    int n = 0;
    while (bus.tx_trig !== v && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_trig_wait"}, 32'(n < 400), 1);
  endtask
  task automatic wait_done(input string tag);
    int n = 0;
    while (bus.done === 2'b00 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_done_wait"}, 32'(n < 400), 1);
  endtask
  // framer: goes busy 2 cycles after it sees the trigger, stays busy 150 cycles
  initial begin
    bus.tx_state = '0;
    forever begin
      @(negedge clk);
      if (phase == 0) begin
        if (frm_en && bus.tx_trig) begin
          phase = 1;
          fcnt = 2;
        end
      end else if (phase == 1) begin
        fcnt--;
        if (fcnt == 0) begin
          bus.tx_state = 4'd5;
          fcnt = 150;
          phase = 2;
        end
      end else begin
        fcnt--;
        if (fcnt == 0) begin
          bus.tx_state = '0;
          phase = 0;
        end
      end
    end
  end
  initial begin
    int n;
    bit saw;
    clr = 1'b1;
    bus.req = '0;
    bus.len0 = '0;
    bus.len1 = '0;
    repeat (3) @(negedge clk);
    chk("rst_gnt", 32'(bus.gnt), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_trig", 32'(bus.tx_trig), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_dlen", 32'(bus.tx_data_length), 0);
    chk("rst_tlen", 32'(bus.tx_total_length), 0);
    chk("rst_sel", 32'(bus.ram_sel), 0);
    chk("rst_err", 32'(bus.err), 0);
    clr = 1'b0;
    @(posedge clk);
    #1 bus.req = 2'b01;
    bus.len0 = 16'd100;
    @(negedge clk);
    chk("idle_busy", 32'(bus.busy), 0);
    @(negedge clk);
    chk("arb_busy", 32'(bus.busy), 1);
    chk("arb_gnt", 32'(bus.gnt), 0);
    @(negedge clk);
    chk("f1_gnt", 32'(bus.gnt), 1);
    chk("f1_trig", 32'(bus.tx_trig), 1);
    chk("f1_sel", 32'(bus.ram_sel), 0);
    chk("f1_dlen", 32'(bus.tx_data_length), 108);
    chk("f1_tlen", 32'(bus.tx_total_length), 128);
    wait_done("f1");
    chk("f1_done", 32'(bus.done), 1);
    chk("f1_gnt_clr", 32'(bus.gnt), 0);
    bus.req = 2'b10;
    bus.len1 = 16'd5;
    @(negedge clk);
    chk("f1_done_pulse", 32'(bus.done), 0);
    chk("gap_busy", 32'(bus.busy), 1);
    n = 1;
    while (!bus.tx_trig && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("ifg_spacing", 32'(n), 15);
    chk("f2_gnt", 32'(bus.gnt), 2);
    chk("f2_sel", 32'(bus.ram_sel), 1);
    chk("f2_dlen", 32'(bus.tx_data_length), 26);
    chk("f2_tlen", 32'(bus.tx_total_length), 46);
    bus.len1 = 16'd3000;
    @(negedge clk);
    chk("f2_dlen_hold", 32'(bus.tx_data_length), 26);
    wait_done("f2");
    chk("f2_done", 32'(bus.done), 2);
    wait_trig(1'b1, "f3");
    chk("f3_gnt", 32'(bus.gnt), 2);
    chk("f3_dlen", 32'(bus.tx_data_length), 1480);
    chk("f3_tlen", 32'(bus.tx_total_length), 1500);
    wait_done("f3");
    bus.req = 2'b11;
    wait_trig(1'b1, "rr1");
    chk("rr1_gnt", 32'(bus.gnt), 1);
    wait_done("rr1");
    wait_trig(1'b1, "rr2");
    chk("rr2_gnt", 32'(bus.gnt), 2);
    wait_done("rr2");
    wait_trig(1'b1, "rr3");
    chk("rr3_gnt", 32'(bus.gnt), 1);
    wait_done("rr3");
    bus.req = 2'b00;
    repeat (20) @(negedge clk);
    bus.req = 2'b01;
    bus.len0 = 16'd200;
    wait_trig(1'b1, "mid");
    wait_trig(1'b0, "mid_end");
    bus.len0 = 16'd50;
    bus.req = 2'b00;
    @(negedge clk);
    chk("mid_dlen", 32'(bus.tx_data_length), 208);
    chk("mid_tlen", 32'(bus.tx_total_length), 228);
    chk("mid_gnt", 32'(bus.gnt), 1);
    wait_done("mid");
    chk("mid_done", 32'(bus.done), 1);
    repeat (20) @(negedge clk);
    chk("mid_no_arb_busy", 32'(bus.busy), 0);
    chk("mid_no_arb_gnt", 32'(bus.gnt), 0);
    bus.req = 2'b01;
    bus.len0 = 16'd64;
    wait_trig(1'b1, "clr");
    wait_trig(1'b0, "clr_end");
    #2 clr = 1'b1;
    #1 chk("clr_gnt", 32'(bus.gnt), 0);
    chk("clr_busy", 32'(bus.busy), 0);
    chk("clr_dlen", 32'(bus.tx_data_length), 0);
    chk("clr_tlen", 32'(bus.tx_total_length), 0);
    chk("clr_trig", 32'(bus.tx_trig), 0);
    @(negedge clk);
    clr = 1'b0;
    bus.req = 2'b00;
    repeat (200) @(negedge clk);
    bus.req = 2'b11;
    wait_trig(1'b1, "rst_last");
    chk("rst_last_gnt", 32'(bus.gnt), 1);
    wait_done("rst_last");
    bus.req = 2'b00;
    repeat (20) @(negedge clk);
`ifdef UDP_TX_SCHED_WDOG_EN
    frm_en = 1'b0;
    bus.req = 2'b01;
    wait_trig(1'b1, "wdog");
    saw = 1'b0;
    repeat (4100) begin
      @(negedge clk);
      saw |= (bus.done != 2'b00);
    end
    bus.req = 2'b00;
    chk("wdog_err", 32'(bus.err), 1);
    chk("wdog_no_done", 32'(saw), 0);
    chk("wdog_gnt", 32'(bus.gnt), 0);
    repeat (30) @(negedge clk);
    chk("wdog_sticky", 32'(bus.err), 1);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("wdog_clr", 32'(bus.err), 0);
`else
    saw = 1'b0;
    chk("err_tied", 32'(bus.err | saw), 0);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
